// File: rtl/lh_pkg.sv
// ---------------------------------------------------------------------------
// lh_pkg
// Shared definitions for the iterative light hash:
//   - lh_state_e  : controller states (IDLE / BUSY / DONE)
//   - char-class bounds used by the charset check
//   - rotl8       : 8-bit rotate left
//   - aes_sbox    : AES forward S-box lookup (256-entry table)
//   - char_is_valid : charset check for both charset modes
// ---------------------------------------------------------------------------
package lh_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lh_state_e;

    localparam logic [7:0] CH_DIGIT_LO = 8'h30;
    localparam logic [7:0] CH_DIGIT_HI = 8'h39;
    localparam logic [7:0] CH_UPPER_LO = 8'h41;
    localparam logic [7:0] CH_UPPER_HI = 8'h5A;
    localparam logic [7:0] CH_LOWER_LO = 8'h61;
    localparam logic [7:0] CH_LOWER_HI = 8'h7A;
    localparam logic [7:0] CH_NULL     = 8'h00;

    localparam logic [7:0] SBOX_LUT [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Rotating a doubled copy left and keeping the top byte gives the
    // wrapped-around bits without a separate right shift.
    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // The byte value itself is the row/column index t[7:4]*16 + t[3:0].
    function automatic logic [7:0] aes_sbox(input logic [7:0] t);
        return SBOX_LUT[t];
    endfunction

    function automatic logic char_is_valid(input logic [7:0] c, input logic allow_any);
        logic alnum;
        alnum = ((c >= CH_DIGIT_LO) && (c <= CH_DIGIT_HI)) ||
                ((c >= CH_UPPER_LO) && (c <= CH_UPPER_HI)) ||
                ((c >= CH_LOWER_LO) && (c <= CH_LOWER_HI));
        return allow_any ? (c != CH_NULL) : alnum;
    endfunction

endpackage

// File: rtl/lh_round.sv
// ---------------------------------------------------------------------------
// lh_round
// One mixing round of the light hash, purely combinational.
// Ports:
//   h_in  [8*NBYTES] : hash state before the round, byte i at [8*i +: 8]
//   c     [8]        : char being absorbed
//   h_out [8*NBYTES] : hash state after the round
// ---------------------------------------------------------------------------
module lh_round
    import lh_pkg::*;
#(
    parameter int NBYTES = 8
) (
    input  logic [8*NBYTES-1:0] h_in,
    input  logic [7:0]          c,
    output logic [8*NBYTES-1:0] h_out
);

    logic [7:0] t;

    // Bytes are updated in place in ascending order, so a neighbour with a
    // lower index than the byte being written has already been replaced in
    // h_out, while a higher one still holds its incoming value.
    always_comb begin
        h_out = h_in;
        t     = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            t = h_out[8*((i + 2) % NBYTES) +: 8] ^ c;
            t = rotl8(t, 3'(i % 8));
            h_out[8*i +: 8] = aes_sbox(t);
        end
    end

endmodule

// File: rtl/light_hash_seq.sv
// ---------------------------------------------------------------------------
// light_hash_seq
// Iterative light hash: absorbs a framed message of chars over a
// valid/ready handshake, runs ROUNDS rounds per accepted char (one round per
// clock) and emits an NBYTES-byte digest with a one-cycle digest_ready pulse.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ptxt_char [8]         : input char
//   ptxt_valid            : char present
//   ptxt_last             : char ends the message (qualified by ptxt_valid)
//   ptxt_ready            : block can take a char this cycle
//   digest_char [8*NBYTES]: digest, byte i at [8*i +: 8]; zero on error
//   digest_ready          : one-cycle pulse, digest_char and error valid
//   err_invalid_ptxt_char : last message contained an invalid char
// ---------------------------------------------------------------------------
module light_hash_seq
    import lh_pkg::*;
#(
    parameter int                  NBYTES    = 8,
    parameter int                  ROUNDS    = 32,
    parameter logic [8*NBYTES-1:0] IV        = '0,
    parameter bit                  ALLOW_ANY = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          ptxt_char,
    input  logic                ptxt_valid,
    input  logic                ptxt_last,
    output logic                ptxt_ready,
    output logic [8*NBYTES-1:0] digest_char,
    output logic                digest_ready,
    output logic                err_invalid_ptxt_char
);

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    lh_state_e           state;
    lh_state_e           state_next;
    logic [8*NBYTES-1:0] h;
    logic [8*NBYTES-1:0] h_next;
    logic [7:0]          c_reg;
    logic                last_reg;
    logic                err_sticky;
    logic [7:0]          round_cnt;

    logic                char_ok;
    logic                load_char;
    logic                flag_bad;
    logic                do_round;
    logic                finish;

    assign char_ok = char_is_valid(ptxt_char, ALLOW_ANY);

    lh_round #(
        .NBYTES (NBYTES)
    ) u_round (
        .h_in  (h),
        .c     (c_reg),
        .h_out (h_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An invalid char skips the rounds entirely; if it closes the message
    // we go straight to DONE so the error digest comes out one edge later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ptxt_valid) begin
                    if (char_ok) begin
                        state_next = BUSY;
                    end else begin
                        state_next = ptxt_last ? DONE : IDLE;
                    end
                end
            end
            BUSY: begin
                if (round_cnt == LAST_ROUND) begin
                    state_next = last_reg ? DONE : IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ptxt_ready = (state == IDLE);
        load_char  = ptxt_ready && ptxt_valid && char_ok;
        flag_bad   = ptxt_ready && ptxt_valid && !char_ok;
        do_round   = (state == BUSY);
        finish     = (state == DONE);
    end

    // DONE publishes the digest (forced to zero when any char was bad) and
    // rearms H and the error flag for the next message in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h                     <= IV;
            c_reg                 <= 8'h00;
            last_reg              <= 1'b0;
            err_sticky            <= 1'b0;
            round_cnt             <= 8'h00;
            digest_char           <= '0;
            digest_ready          <= 1'b0;
            err_invalid_ptxt_char <= 1'b0;
        end else begin
            digest_ready <= 1'b0;
            if (load_char) begin
                c_reg     <= ptxt_char;
                last_reg  <= ptxt_last;
                round_cnt <= 8'h00;
            end
            if (flag_bad) begin
                err_sticky <= 1'b1;
            end
            if (do_round) begin
                h         <= h_next;
                round_cnt <= round_cnt + 8'd1;
            end
            if (finish) begin
                digest_char           <= err_sticky ? '0 : h;
                err_invalid_ptxt_char <= err_sticky;
                digest_ready          <= 1'b1;
                h                     <= IV;
                err_sticky            <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_light_hash_seq.sv
// ---------------------------------------------------------------------------
// tb_light_hash_seq
// Self-checking bench for light_hash_seq. Four instances with different
// parameter sets share the char inputs; sel routes ptxt_valid to one of
// them and muxes that instance's outputs onto the m_* monitor signals.
// Expected digests come from a byte-array model whose S-box is derived from
// GF(2^8) inversion plus the AES affine map.
// ---------------------------------------------------------------------------
module tb_light_hash_seq;

    localparam logic [15:0]  IV2 = 16'hA55A;
    localparam logic [255:0] IV3 = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

    typedef struct {
        logic [255:0] dig;
        bit           err;
    } res_t;

    typedef struct {
        int unsigned sel;
        int unsigned len;
        logic [31:0] ch;
        bit          exp_err;
        int unsigned exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ptxt_char;
    logic        ptxt_valid;
    logic        ptxt_last;
    int unsigned sel;

    logic        ready_0, ready_1, ready_2, ready_3;
    logic        dr_0, dr_1, dr_2, dr_3;
    logic        err_0, err_1, err_2, err_3;
    logic [63:0]  digest_0, digest_1;
    logic [15:0]  digest_2;
    logic [255:0] digest_3;

    logic         m_ready, m_dr, m_err;
    logic [255:0] m_digest;

    int unsigned  cfg_n   [4];
    int unsigned  cfg_r   [4];
    logic [255:0] cfg_iv  [4];
    bit           cfg_any [4];
    logic [7:0]   sbox_tab [256];

    int unsigned  n_compared   = 0;
    int unsigned  n_mismatched = 0;
    int unsigned  cyc          = 0;
    int unsigned  pulse_cnt    = 0;
    int unsigned  pulse_cyc    = 0;
    int unsigned  low_cnt      = 0;
    int unsigned  acc_log [$];
    logic [255:0] cap_digest;
    logic         cap_err;

    always #5 clk = ~clk;

    light_hash_seq #(.NBYTES(8), .ROUNDS(32), .IV(64'h0), .ALLOW_ANY(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid && sel == 0),
        .ptxt_last(ptxt_last), .ptxt_ready(ready_0), .digest_char(digest_0),
        .digest_ready(dr_0), .err_invalid_ptxt_char(err_0));

    light_hash_seq #(.NBYTES(8), .ROUNDS(32), .IV(64'h0), .ALLOW_ANY(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid && sel == 1),
        .ptxt_last(ptxt_last), .ptxt_ready(ready_1), .digest_char(digest_1),
        .digest_ready(dr_1), .err_invalid_ptxt_char(err_1));

    light_hash_seq #(.NBYTES(2), .ROUNDS(1), .IV(IV2), .ALLOW_ANY(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid && sel == 2),
        .ptxt_last(ptxt_last), .ptxt_ready(ready_2), .digest_char(digest_2),
        .digest_ready(dr_2), .err_invalid_ptxt_char(err_2));

    light_hash_seq #(.NBYTES(32), .ROUNDS(255), .IV(IV3), .ALLOW_ANY(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid && sel == 3),
        .ptxt_last(ptxt_last), .ptxt_ready(ready_3), .digest_char(digest_3),
        .digest_ready(dr_3), .err_invalid_ptxt_char(err_3));

    always_comb begin
        m_ready  = ready_0;
        m_dr     = dr_0;
        m_err    = err_0;
        m_digest = 256'(digest_0);
        case (sel)
            1: begin m_ready = ready_1; m_dr = dr_1; m_err = err_1; m_digest = 256'(digest_1); end
            2: begin m_ready = ready_2; m_dr = dr_2; m_err = err_2; m_digest = 256'(digest_2); end
            3: begin m_ready = ready_3; m_dr = dr_3; m_err = err_3; m_digest = 256'(digest_3); end
            default: ;
        endcase
    end

    // Edge counter and accept log; reads happen before the DUT's registers
    // update, so this sees the handshake exactly as the DUT does.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ptxt_valid && m_ready) acc_log.push_back(cyc);
    end

    // Output monitor, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (!m_ready) low_cnt = low_cnt + 1;
        if (m_dr) begin
            pulse_cnt  = pulse_cnt + 1;
            pulse_cyc  = cyc;
            cap_digest = m_digest;
            cap_err    = m_err;
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotlRef(input logic [7:0] v, input int unsigned n);
        logic [7:0] a, b;
        a = v << n;
        b = v >> (8 - n);
        return (n == 0) ? v : (a | b);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[v] = inv ^ rotlRef(inv, 1) ^ rotlRef(inv, 2) ^ rotlRef(inv, 3)
                          ^ rotlRef(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic bit charOk(input logic [7:0] c, input bit any);
        if (any) return c != 8'h00;
        return c inside {[8'h30:8'h39], [8'h41:8'h5A], [8'h61:8'h7A]};
    endfunction

    function automatic res_t modelHash(input int unsigned s, input logic [7:0] msg[$]);
        res_t        r;
        logic [7:0]  hb [32];
        logic [7:0]  t;
        int unsigned n;
        n = cfg_n[s];
        r.err = 1'b0;
        r.dig = '0;
        for (int i = 0; i < 32; i++) hb[i] = cfg_iv[s][8*i +: 8];
        foreach (msg[k]) begin
            if (!charOk(msg[k], cfg_any[s])) begin
                r.err = 1'b1;
                continue;
            end
            for (int rr = 0; rr < int'(cfg_r[s]); rr++)
                for (int i = 0; i < int'(n); i++) begin
                    t     = hb[(i + 2) % n] ^ msg[k];
                    t     = rotlRef(t, i % 8);
                    hb[i] = sbox_tab[t];
                end
        end
        if (!r.err)
            for (int i = 0; i < int'(n); i++) r.dig[8*i +: 8] = hb[i];
        return r;
    endfunction

    // ---------------- checking / driving ----------------
    task automatic checkOutput(input string what, input logic [255:0] got, input logic [255:0] exp);
        n_compared = n_compared + 1;
        if (got !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, got, exp);
        end
    endtask

    // Called and returns at a negedge. Each char is held until an edge at
    // which ptxt_ready was high; with gap_max=0 valid never drops mid-message.
    task automatic applyStimulus(input int unsigned s, input logic [7:0] msg[$], input int unsigned gap_max);
        int unsigned waited;
        int unsigned gap;
        sel = s;
        for (int k = 0; k < msg.size(); k++) begin
            gap = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
            if (gap > 0) begin
                ptxt_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            ptxt_char  = msg[k];
            ptxt_last  = (k == msg.size() - 1);
            ptxt_valid = 1'b1;
            waited = 0;
            while (!m_ready && waited < cfg_r[s] + 20) begin
                @(negedge clk);
                waited++;
            end
            if (!m_ready) begin
                checkOutput("accept_timeout", 256'(m_ready), 256'(1));
                ptxt_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        ptxt_valid = 1'b0;
        ptxt_last  = 1'b0;
    endtask

    task automatic waitPulse(input int unsigned pc0, input int unsigned budget, output bit ok);
        int unsigned w;
        w = 0;
        while (pulse_cnt == pc0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        ok = (pulse_cnt != pc0);
        if (!ok) checkOutput("pulse_timeout", 256'(0), 256'(1));
    endtask

    // exp_lat: edges from the last accept to the edge that sets digest_ready.
    task automatic runMessage(input string name, input int unsigned s, input logic [7:0] msg[$],
                              input int unsigned gap_max, input bit exp_err, input int unsigned exp_lat);
        res_t        exp;
        int unsigned pc0, a0;
        bit          ok;
        exp = modelHash(s, msg);
        pc0 = pulse_cnt;
        a0  = acc_log.size();
        applyStimulus(s, msg, gap_max);
        waitPulse(pc0, cfg_r[s] + 20, ok);
        if (ok) begin
            checkOutput({name, ".digest"}, cap_digest, exp.dig);
            checkOutput({name, ".err"}, 256'(cap_err), 256'(exp_err));
            checkOutput({name, ".accepts"}, 256'(acc_log.size() - a0), 256'(msg.size()));
            if (acc_log.size() > a0)
                checkOutput({name, ".latency"}, 256'(pulse_cyc - acc_log[acc_log.size() - 1]), 256'(exp_lat));
            repeat (3) @(negedge clk);
            checkOutput({name, ".pulses"}, 256'(pulse_cnt - pc0), 256'(1));
            checkOutput({name, ".hold"}, m_digest, exp.dig);
            checkOutput({name, ".dr_clear"}, 256'(m_dr), 256'(0));
        end
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, ".ready"}, 256'({ready_0, ready_1, ready_2, ready_3}), 256'(4'hF));
        checkOutput({name, ".dr"}, 256'({dr_0, dr_1, dr_2, dr_3}), 256'(0));
        checkOutput({name, ".err"}, 256'({err_0, err_1, err_2, err_3}), 256'(0));
        checkOutput({name, ".dig0"}, 256'(digest_0), 256'(0));
        checkOutput({name, ".dig1"}, 256'(digest_1), 256'(0));
        checkOutput({name, ".dig2"}, 256'(digest_2), 256'(0));
        checkOutput({name, ".dig3"}, digest_3, 256'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t        vecs [$];
        logic [7:0]  msg [$];
        int unsigned a0;
        int unsigned pc0;
        int unsigned r;

        cfg_n   = '{8, 8, 2, 32};
        cfg_r   = '{32, 32, 1, 255};
        cfg_iv  = '{256'(0), 256'(0), 256'(IV2), IV3};
        cfg_any = '{1'b0, 1'b1, 1'b0, 1'b0};

        // sel, len, chars (first char in low byte), exp_err, exp_lat
        vecs.push_back('{0, 1, 32'h00000061, 1'b0, 33});
        vecs.push_back('{0, 3, 32'h00396241, 1'b0, 33});
        vecs.push_back('{0, 1, 32'h00000000, 1'b1, 1});
        vecs.push_back('{0, 3, 32'h007A2341, 1'b1, 33});
        vecs.push_back('{0, 1, 32'h0000007A, 1'b0, 33});
        vecs.push_back('{1, 1, 32'h00000023, 1'b0, 33});
        vecs.push_back('{1, 3, 32'h00FF8078, 1'b0, 33});
        vecs.push_back('{1, 3, 32'h00620061, 1'b1, 33});
        vecs.push_back('{2, 2, 32'h00006948, 1'b0, 2});
        vecs.push_back('{3, 2, 32'h0000305A, 1'b0, 256});

        buildSbox();
        sel        = 0;
        ptxt_char  = 8'h00;
        ptxt_valid = 1'b0;
        ptxt_last  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "a": ready stays low from the accept edge until the edge after DONE.
        msg = '{8'h61};
        low_cnt = 0;
        runMessage("msg_a", 0, msg, 0, 1'b0, 33);
        checkOutput("msg_a.ready_low", 256'(low_cnt), 256'(33));

        // "Ab9" with valid held high: one accept every ROUNDS+1 edges.
        msg = '{8'h41, 8'h62, 8'h39};
        a0  = acc_log.size();
        runMessage("msg_Ab9", 0, msg, 0, 1'b0, 33);
        if (acc_log.size() >= a0 + 3) begin
            checkOutput("msg_Ab9.space1", 256'(acc_log[a0 + 1] - acc_log[a0]), 256'(33));
            checkOutput("msg_Ab9.space2", 256'(acc_log[a0 + 2] - acc_log[a0 + 1]), 256'(33));
        end

        for (int v = 0; v < vecs.size(); v++) begin
            msg.delete();
            for (int k = 0; k < int'(vecs[v].len); k++) msg.push_back(vecs[v].ch[8*k +: 8]);
            runMessage($sformatf("vec%0d", v), vecs[v].sel, msg, 0, vecs[v].exp_err, vecs[v].exp_lat);
        end

        // Reset in the middle of absorbing a char: outputs clear at once.
        msg = '{8'h61};
        applyStimulus(0, msg, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetState("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pc0 = pulse_cnt;
        repeat (40) @(negedge clk);
        checkOutput("rst_mid.discard", 256'(pulse_cnt), 256'(pc0));
        runMessage("rst_rerun", 0, msg, 0, 1'b0, 33);

        // Random alphanumeric messages with random valid gaps.
        for (int m = 0; m < 26; m++) begin
            int unsigned s;
            int unsigned len;
            s   = (m < 4) ? 0 : ((m < 24) ? 2 : 3);
            len = $urandom_range(16, 1);
            msg.delete();
            for (int k = 0; k < int'(len); k++) begin
                r = $urandom_range(61, 0);
                if (r < 10)      msg.push_back(8'(8'h30 + r));
                else if (r < 36) msg.push_back(8'(8'h41 + r - 10));
                else             msg.push_back(8'(8'h61 + r - 36));
            end
            runMessage($sformatf("rand%0d_sel%0d", m, s), s, msg, 3, 1'b0, cfg_r[s] + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
